// File: rtl/mold_retrans_req.sv
// mold_retrans_req: builds MoldUDP64 retransmission requests from miss reports.
//
// A miss report {sid, seq_start, cnt} is split into requests of at most
// MAX_REQ_CNT messages. Each request is a 20-byte packet (Session 10B,
// Sequence Number 8B, Message Count 2B, every field MSB first) sent as
// three beats on a 64-bit valid/ready stream. Byte n of the packet goes on
// lane (n mod 8) of beat (n div 8).
// One report can be in progress and one more can wait in a pending slot.
// Any further report is dropped and counted.
//
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   miss_v_i           miss report strobe (no backpressure)
//   miss_sid_i         session of the missed range
//   miss_seq_start_i   first missing sequence number
//   miss_seq_cnt_i     number of missing messages (0 = ignored)
//   req_valid_o/ready  request beat handshake
//   req_data_o         beat data, lane j = data[8j+7:8j]
//   req_keep_o         byte-valid per lane
//   req_last_o         last beat of a request
//   busy_o             active request or pending report held
//   drop_o             one-cycle pulse when a report is discarded
//   drop_cnt_o         saturating count of discarded reports
//
// Build option: define REQ_THROTTLE_EN to insert GAP_CYCLES idle cycles
// before every request that follows a completed request.

module mold_retrans_req #(
   parameter int unsigned     SID_W       = 80,
   parameter int unsigned     SEQ_NUM_W   = 64,
   parameter int unsigned     ML_W        = 16,
   parameter logic [ML_W-1:0] MAX_REQ_CNT = '1,
   parameter int unsigned     GAP_CYCLES  = 16
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 miss_v_i,
   input  logic [SID_W-1:0]     miss_sid_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_cnt_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [63:0]          req_data_o,
   output logic [7:0]           req_keep_o,
   output logic                 req_last_o,
   output logic                 busy_o,
   output logic                 drop_o,
   output logic [15:0]          drop_cnt_o
);

   localparam int unsigned PKT_W = SID_W + SEQ_NUM_W + ML_W;
`ifdef REQ_THROTTLE_EN
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`endif

`ifdef REQ_THROTTLE_EN
   typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_BEAT2, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_BEAT2} state_t;
`endif

   // Messages carried by the next request given the remaining count.
   function automatic logic [ML_W-1:0] chunk_of(input logic [SEQ_NUM_W-1:0] rem);
      logic [ML_W-1:0] c;
      if (rem > SEQ_NUM_W'(MAX_REQ_CNT)) c = MAX_REQ_CNT;
      else                               c = rem[ML_W-1:0];
      return c;
   endfunction

   // Beat k of the packet: shift beat k's bytes to the top of the packed
   // packet, then place them MSB-first onto lanes 0..7. Bytes past the end
   // of the packet shift in as zero.
   function automatic logic [63:0] beat_data(input logic [SID_W-1:0]     sid,
                                             input logic [SEQ_NUM_W-1:0] seq,
                                             input logic [ML_W-1:0]      cnt,
                                             input int unsigned          k);
      logic [PKT_W-1:0] sh;
      logic [63:0]      d;
      sh = {sid, seq, cnt} << (64 * k);
      d  = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         d[8*j +: 8] = sh[PKT_W-1-8*j -: 8];
      end
      return d;
   endfunction

   state_t               state_q;
   logic [SID_W-1:0]     sid_q;
   logic [SEQ_NUM_W-1:0] seq_q;
   logic [SEQ_NUM_W-1:0] rem_q;
   logic                 pend_q;
   logic [SID_W-1:0]     pend_sid_q;
   logic [SEQ_NUM_W-1:0] pend_seq_q;
   logic [SEQ_NUM_W-1:0] pend_cnt_q;
   logic                 valid_q;
   logic [63:0]          data_q;
   logic [7:0]           keep_q;
   logic                 last_q;
   logic                 drop_q;
   logic [15:0]          drop_cnt_q;
`ifdef REQ_THROTTLE_EN
   logic [GAP_W-1:0]     gap_q;
`endif

   logic                 new_v;
   logic                 done;
   logic [ML_W-1:0]      chunk_cur;
   logic [SEQ_NUM_W-1:0] seq_adv;
   logic [SEQ_NUM_W-1:0] rem_adv;
   logic [SID_W-1:0]     sid_d;
   logic [SEQ_NUM_W-1:0] seq_d;
   logic [SEQ_NUM_W-1:0] rem_d;
   logic                 go_d;
   logic                 pend_load;
   logic                 pend_clr;
   logic                 drop_now;

   // Slot bookkeeping. sid_d/seq_d/rem_d/go_d describe the request that
   // becomes active when the current one finishes (or when IDLE loads).
   // A report arriving on the cycle a request completes goes to whichever
   // slot that completion frees, so it is never dropped for that reason.
   always_comb begin
      new_v     = miss_v_i & (miss_seq_cnt_i != '0);
      done      = (state_q == S_BEAT2) & req_ready_i;
      chunk_cur = chunk_of(rem_q);
      seq_adv   = seq_q + SEQ_NUM_W'(chunk_cur);
      rem_adv   = rem_q - SEQ_NUM_W'(chunk_cur);
      sid_d     = sid_q;
      seq_d     = seq_adv;
      rem_d     = rem_adv;
      go_d      = 1'b0;
      pend_load = 1'b0;
      pend_clr  = 1'b0;
      drop_now  = 1'b0;
      if (state_q == S_IDLE) begin
         // Pending is always empty in IDLE.
         sid_d = miss_sid_i;
         seq_d = miss_seq_start_i;
         rem_d = miss_seq_cnt_i;
         go_d  = new_v;
      end else if (done) begin
         if (rem_adv != '0) begin
            go_d = 1'b1;
            if (new_v) begin
               if (pend_q) drop_now  = 1'b1;
               else        pend_load = 1'b1;
            end
         end else if (pend_q) begin
            sid_d     = pend_sid_q;
            seq_d     = pend_seq_q;
            rem_d     = pend_cnt_q;
            go_d      = 1'b1;
            pend_clr  = 1'b1;
            pend_load = new_v;
         end else if (new_v) begin
            sid_d = miss_sid_i;
            seq_d = miss_seq_start_i;
            rem_d = miss_seq_cnt_i;
            go_d  = 1'b1;
         end
      end else if (new_v) begin
         if (pend_q) drop_now  = 1'b1;
         else        pend_load = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         sid_q      <= '0;
         seq_q      <= '0;
         rem_q      <= '0;
         pend_q     <= 1'b0;
         pend_sid_q <= '0;
         pend_seq_q <= '0;
         pend_cnt_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         keep_q     <= '0;
         last_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
`ifdef REQ_THROTTLE_EN
         gap_q      <= '0;
`endif
      end else begin
         // Pending slot
         if (pend_load) begin
            pend_q     <= 1'b1;
            pend_sid_q <= miss_sid_i;
            pend_seq_q <= miss_seq_start_i;
            pend_cnt_q <= miss_seq_cnt_i;
         end else if (pend_clr) begin
            pend_q <= 1'b0;
         end

         // Drop reporting
         drop_q <= drop_now;
         if (drop_now && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;

         // Request FSM
         case (state_q)
            S_IDLE: begin
               if (go_d) begin
                  sid_q   <= sid_d;
                  seq_q   <= seq_d;
                  rem_q   <= rem_d;
                  state_q <= S_BEAT0;
                  valid_q <= 1'b1;
                  data_q  <= beat_data(sid_d, seq_d, chunk_of(rem_d), 0);
                  keep_q  <= 8'hFF;
                  last_q  <= 1'b0;
               end
            end
            S_BEAT0: begin
               if (req_ready_i) begin
                  state_q <= S_BEAT1;
                  data_q  <= beat_data(sid_q, seq_q, chunk_cur, 1);
               end
            end
            S_BEAT1: begin
               if (req_ready_i) begin
                  state_q <= S_BEAT2;
                  data_q  <= beat_data(sid_q, seq_q, chunk_cur, 2);
                  keep_q  <= 8'h0F;
                  last_q  <= 1'b1;
               end
            end
            S_BEAT2: begin
               if (req_ready_i) begin
                  sid_q <= sid_d;
                  seq_q <= seq_d;
                  rem_q <= rem_d;
                  if (go_d) begin
`ifdef REQ_THROTTLE_EN
                     state_q <= S_GAP;
                     gap_q   <= GAP_W'(GAP_CYCLES - 1);
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     keep_q  <= '0;
                     last_q  <= 1'b0;
`else
                     state_q <= S_BEAT0;
                     valid_q <= 1'b1;
                     data_q  <= beat_data(sid_d, seq_d, chunk_of(rem_d), 0);
                     keep_q  <= 8'hFF;
                     last_q  <= 1'b0;
`endif
                  end else begin
                     state_q <= S_IDLE;
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     keep_q  <= '0;
                     last_q  <= 1'b0;
                  end
               end
            end
`ifdef REQ_THROTTLE_EN
            S_GAP: begin
               // Active regs already hold the next request.
               if (gap_q == '0) begin
                  state_q <= S_BEAT0;
                  valid_q <= 1'b1;
                  data_q  <= beat_data(sid_q, seq_q, chunk_cur, 0);
                  keep_q  <= 8'hFF;
                  last_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               data_q  <= '0;
               keep_q  <= '0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_valid_o = valid_q;
   assign req_data_o  = data_q;
   assign req_keep_o  = keep_q;
   assign req_last_o  = last_q;
   assign drop_o      = drop_q;
   assign drop_cnt_o  = drop_cnt_q;
   assign busy_o      = (state_q != S_IDLE) | pend_q;

endmodule

// File: tb/tb_mold_retrans_req.sv
// Bench for mold_retrans_req: directed miss reports, expected beats queued
// at issue time and compared by an independent monitor on each handshake.

module tb_mold_retrans_req;

`ifdef REQ_THROTTLE_EN
   localparam int unsigned GAP = 4;
`else
   localparam int unsigned GAP = 0;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic        clk        = 1'b0;
   logic        nreset     = 1'b0;
   logic        miss_v     = 1'b0;
   logic [79:0] miss_sid   = '0;
   logic [63:0] miss_start = '0;
   logic [63:0] miss_cnt   = '0;
   logic        req_ready  = 1'b1;
   logic        req_valid;
   logic [63:0] req_data;
   logic [7:0]  req_keep;
   logic        req_last;
   logic        busy;
   logic        drop;
   logic [15:0] drop_cnt;

   beat_t       exp_q[$];
   beat_t       mon_got;
   beat_t       mon_exp;
   int          errors = 0;
   int          checks = 0;
   int unsigned gap_run = 0;
   int unsigned last_gap = 0;
   bit          after_last = 1'b1;

   logic [79:0] sid_a, sid_b, sid_c;
   beat_t       bp_exp;

   always #5 clk = ~clk;

   mold_retrans_req #(
      .SID_W       (80),
      .SEQ_NUM_W   (64),
      .ML_W        (16),
      .MAX_REQ_CNT (16'hFFFF),
      .GAP_CYCLES  ((GAP == 0) ? 16 : GAP)
   ) dut (
      .clk              (clk),
      .nreset           (nreset),
      .miss_v_i         (miss_v),
      .miss_sid_i       (miss_sid),
      .miss_seq_start_i (miss_start),
      .miss_seq_cnt_i   (miss_cnt),
      .req_valid_o      (req_valid),
      .req_ready_i      (req_ready),
      .req_data_o       (req_data),
      .req_keep_o       (req_keep),
      .req_last_o       (req_last),
      .busy_o           (busy),
      .drop_o           (drop),
      .drop_cnt_o       (drop_cnt)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Lane 0 receives the most significant byte of x.
   function automatic logic [63:0] bswap64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = x[63-8*i -: 8];
      return r;
   endfunction

   task automatic push_req(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
      exp_q.push_back(beat_t'{bswap64(sid[79:16]), 8'hFF, 1'b0});
      exp_q.push_back(beat_t'{bswap64({sid[15:0], seq[63:16]}), 8'hFF, 1'b0});
      exp_q.push_back(beat_t'{bswap64({seq[15:0], cnt, 32'h0}), 8'h0F, 1'b1});
   endtask

   task automatic send_miss(input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
      miss_sid   = sid;
      miss_start = start;
      miss_cnt   = cnt;
      miss_v     = 1'b1;
      @(posedge clk);
      #1;
      miss_v     = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!busy && exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_busy", 128'(busy), 128'(0));
      check("drain_queue", 128'(exp_q.size()), 128'(0));
   endtask

   // Monitor: one comparison per accepted beat.
   always @(negedge clk) begin
      if (nreset) begin
         if (req_valid && req_ready) begin
            mon_got = {req_data, req_keep, req_last};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h with nothing expected", mon_got);
            end else begin
               mon_exp = exp_q.pop_front();
               check("beat", 128'(mon_got), 128'(mon_exp));
            end
            if (after_last) last_gap = gap_run;
            after_last = req_last;
            if (req_last) gap_run = 0;
         end else if (!req_valid) begin
            gap_run++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sid_a = 80'h0102_0304_0506_0708_090A;
      sid_b = 80'hA1B2_C3D4_E5F6_0718_293A;
      sid_c = 80'h00FF_EE00_DDCC_BBAA_9988;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 128'(req_valid), 128'(0));
      check("rst_last", 128'(req_last), 128'(0));
      check("rst_data", 128'(req_data), 128'(0));
      check("rst_keep", 128'(req_keep), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_drop", 128'(drop), 128'(0));
      check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
      nreset = 1'b1;
      @(posedge clk);
      #1;

      // Single miss, literal beat values
      exp_q.push_back(beat_t'{64'h0000_0000_0000_0000, 8'hFF, 1'b0});
      exp_q.push_back(beat_t'{64'h0000_0000_0000_0100, 8'hFF, 1'b0});
      exp_q.push_back(beat_t'{64'h0000_0000_0300_0500, 8'h0F, 1'b1});
      send_miss(80'h1, 64'h5, 64'd3);
      check("latency_valid", 128'(req_valid), 128'(1));
      check("busy_active", 128'(busy), 128'(1));
      wait_idle();

      // Split across two requests; gap between them
      push_req(sid_a, 64'h5, 16'hFFFF);
      push_req(sid_a, 64'h1_0004, 16'h0002);
      send_miss(sid_a, 64'h5, 64'h1_0001);
      wait_idle();
      check("split_gap", 128'(last_gap), 128'(GAP));

      // Sequence wrap mod 2^64 with split
      push_req(sid_c, 64'hFFFF_FFFF_FFFF_FFFE, 16'hFFFF);
      push_req(sid_c, 64'h0000_0000_0000_FFFD, 16'h0001);
      send_miss(sid_c, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1_0000);
      wait_idle();

      // Backpressure for 10 cycles during BEAT1
      push_req(sid_b, 64'h1122_3344_5566_7788, 16'h0009);
      bp_exp = beat_t'{64'h6655_4433_2211_3A29, 8'hFF, 1'b0};
      send_miss(sid_b, 64'h1122_3344_5566_7788, 64'd9);
      @(posedge clk);
      #1;
      req_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", 128'({req_valid, req_data, req_keep, req_last}),
               128'({1'b1, bp_exp.data, bp_exp.keep, bp_exp.last}));
         @(posedge clk);
         #1;
      end
      req_ready = 1'b1;
      wait_idle();

      // New report on the cycle a request completes: no drop
      push_req(sid_a, 64'd100, 16'd1);
      push_req(sid_b, 64'd200, 16'd2);
      send_miss(sid_a, 64'd100, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      send_miss(sid_b, 64'd200, 64'd2);
      check("same_cycle_drop", 128'(drop), 128'(0));
      wait_idle();
      check("same_cycle_drop_cnt", 128'(drop_cnt), 128'(0));

      // Zero-count report is ignored
      send_miss(sid_c, 64'd7, 64'd0);
      check("cnt0_busy", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      check("cnt0_drop", 128'(drop), 128'(0));
      check("cnt0_valid", 128'(req_valid), 128'(0));

      // Overload: active, pending, dropped
      push_req(sid_a, 64'd10, 16'd4);
      push_req(sid_b, 64'd20, 16'd5);
      send_miss(sid_a, 64'd10, 64'd4);
      send_miss(sid_b, 64'd20, 64'd5);
      send_miss(sid_c, 64'd30, 64'd6);
      check("ovl_drop_pulse", 128'(drop), 128'(1));
      check("ovl_drop_cnt", 128'(drop_cnt), 128'(1));
      @(posedge clk);
      #1;
      check("ovl_drop_end", 128'(drop), 128'(0));
      wait_idle();
      check("ovl_drop_cnt_final", 128'(drop_cnt), 128'(1));

      // Async reset mid-BEAT1 with pending full
      exp_q.push_back(beat_t'{bswap64(sid_b[79:16]), 8'hFF, 1'b0});
      send_miss(sid_b, 64'd40, 64'd3);
      send_miss(sid_a, 64'd50, 64'd3);
      check("pre_rst_busy", 128'(busy), 128'(1));
      #2;
      nreset = 1'b0;
      #1;
      check("mid_rst_valid", 128'(req_valid), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_drop_cnt", 128'(drop_cnt), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_valid", 128'(req_valid), 128'(0));
      check("post_rst_busy", 128'(busy), 128'(0));
      check("post_rst_queue", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
